wb_retire_unit: RTL and testbench
=================================

// Module: wb_retire_unit
// PURPOSE
// Writeback/retire stage: consumer end of the MEM/WB pipeline register. Selects writeback data,
// drives the register-file write port, and waits on the multi-cycle divider (valid/ack handshake),
// stalling MEM/WB while it waits. Reports retirement and traps, and keeps the instret counter.
// PARAMETERS
// XLEN         32  datapath width
// CNT_W        64  instret counter width
// DIV_TIMEOUT  64  divider wait limit in cycles; 0 disables the timeout
// PORTS
// clk             in   1     clock, rising edge
// reset           in   1     synchronous, active-high
// wb_valid_in     in   1     MEM/WB holds a live instruction
// mem_data_in     in   XLEN  load data, already extended
// ALU_res_in      in   XLEN  ALU result
// pc_in           in   XLEN  instruction PC
// instr_in        in   32    instruction word
// csr_rdata_in    in   XLEN  CSR read data
// addr_rd_in      in   5     destination register
// WBSel_in        in   2     00 mem, 01 ALU, 10 pc+4, 11 CSR
// regWEn_in       in   1     write enable for rd
// trapReq_in      in   1     instruction raised a trap
// is_jalr_in      in   1     JALR; writes pc+4 regardless of WBSel
// is_div_in       in   1     result comes from the divider
// div_valid_in    in   1     divider result valid
// div_result_in   in   XLEN  divider result
// div_ack_out     out  1     combinational; accepts div_result_in this cycle
// stall_out       out  1     combinational; MEM/WB must hold its inputs stable
// rf_we_out       out  1     registered RF write enable
// rf_waddr_out    out  5     registered RF write address
// rf_wdata_out    out  XLEN  registered RF write data
// retire_valid_out out 1     registered one-cycle pulse per retired instruction
// retire_pc_out   out  XLEN  PC of the retired or trapped instruction
// retire_instr_out out 32    instruction word of the retired or trapped instruction
// trap_out        out  1     registered one-cycle trap pulse
// div_timeout_out out  1     qualifies trap_out; trap caused by divider timeout
// instret_out     out  CNT_W retired-instruction count
// BEHAVIOUR
// Reset: all registered outputs are 0, instret_out is 0, state is RUN and the timeout counter is 0.
// Reset during DIV_WAIT drops the divide with no write and no retire.
// "accept" means wb_valid_in & !stall_out. All effects appear one cycle after accept; latency is 1.
// Data select: is_jalr_in or WBSel=10 -> pc_in+4, mod 2^XLEN. Otherwise mem, ALU or CSR per WBSel.
// is_div_in overrides the select with div_result_in.
// rf_we_out = regWEn_in & addr_rd_in!=0 & !trapReq_in. Writes to x0 are always suppressed.
// Trap (trapReq_in on accept): trap_out=1, no RF write, no retire, instret unchanged.
// trapReq_in has priority over is_div_in; the divider is not waited on.
// Non-trap accept: retire_valid_out=1 and instret_out increments, wrapping at 2^CNT_W.
// FSM RUN:
// - valid & is_div & !trap & !div_valid_in -> stall_out=1, go to DIV_WAIT, timeout counter cleared.
// - valid & is_div & div_valid_in -> div_ack_out=1, completes immediately with no stall.
// FSM DIV_WAIT:
// - stall_out=1 while div_valid_in=0 and the timeout counter increments.
// - On div_valid_in: div_ack_out=1, stall_out=0, write and retire, go to RUN.
// - If DIV_TIMEOUT!=0 and the counter reaches DIV_TIMEOUT-1 with no valid: stall_out=0, trap_out=1,
//   div_timeout_out=1, no write, go to RUN.
// - If div_valid_in and timeout occur in the same cycle, div_valid_in wins.
// div_ack_out is never asserted without div_valid_in, or while wb_valid_in=0.
// wb_valid_in=0: rf_we_out, retire_valid_out and trap_out are 0 next cycle. Data outputs hold.
// TESTING
// ALU op: WBSel=01, ALU=0x1234, rd=5, regWEn -> next cycle rf_we=1, waddr=5, wdata=0x1234, instret=1.
// JALR: pc=0x100, is_jalr, WBSel=01 -> wdata=0x104. Same instruction with rd=0 -> rf_we=0, retire=1.
// Divide: div_valid arrives 3 cycles after accept -> stall high for 3 cycles, ack on cycle 4,
//   wdata=div_result one cycle later.
// Trap with is_div=1 -> no stall, trap_out=1, rf_we=0, retire=0, instret unchanged.
// Timeout: DIV_TIMEOUT=4, div never valid -> stall for 4 cycles, then trap_out=1, div_timeout_out=1.
// Reset asserted in DIV_WAIT -> next cycle stall=0 and all outputs 0. Preload instret=2^64-1,
//   retire once -> instret=0.

Source files
------------

// File: rtl/wb_retire_unit.sv
// ---------------------------------------------------------------------------
// wb_retire_unit
//   Writeback/retire stage at the consumer end of the MEM/WB register.
//   Chooses the writeback value, drives the register-file write port, waits
//   on the multi-cycle divider through a valid/ack handshake (stalling
//   MEM/WB while it waits), reports retirement and traps, and counts retired
//   instructions.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   wb_valid_in         MEM/WB holds a live instruction
//   mem_data_in         load data (already extended)
//   ALU_res_in          ALU result
//   pc_in, instr_in     PC and instruction word of the instruction
//   csr_rdata_in        CSR read data
//   addr_rd_in          destination register
//   WBSel_in            00 mem, 01 ALU, 10 pc+4, 11 CSR
//   regWEn_in           rd write enable
//   trapReq_in          instruction raised a trap
//   is_jalr_in          JALR, writes pc+4
//   is_div_in           result comes from the divider
//   div_valid_in        divider result valid
//   div_result_in       divider result
//   div_ack_out         (comb) divider result consumed this cycle
//   stall_out           (comb) MEM/WB must hold its inputs
//   rf_we_out/rf_waddr_out/rf_wdata_out  registered RF write port
//   retire_valid_out    one-cycle pulse per retired instruction
//   retire_pc_out/retire_instr_out       PC/instruction of retired or trapped op
//   trap_out            one-cycle trap pulse
//   div_timeout_out     trap was caused by a divider timeout
//   instret_out         retired-instruction counter
// ---------------------------------------------------------------------------
module wb_retire_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 64,
   parameter int unsigned DIV_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_valid_in,
   input  logic [XLEN-1:0]  mem_data_in,
   input  logic [XLEN-1:0]  ALU_res_in,
   input  logic [XLEN-1:0]  pc_in,
   input  logic [31:0]      instr_in,
   input  logic [XLEN-1:0]  csr_rdata_in,
   input  logic [4:0]       addr_rd_in,
   input  logic [1:0]       WBSel_in,
   input  logic             regWEn_in,
   input  logic             trapReq_in,
   input  logic             is_jalr_in,
   input  logic             is_div_in,
   input  logic             div_valid_in,
   input  logic [XLEN-1:0]  div_result_in,
   output logic             div_ack_out,
   output logic             stall_out,
   output logic             rf_we_out,
   output logic [4:0]       rf_waddr_out,
   output logic [XLEN-1:0]  rf_wdata_out,
   output logic             retire_valid_out,
   output logic [XLEN-1:0]  retire_pc_out,
   output logic [31:0]      retire_instr_out,
   output logic             trap_out,
   output logic             div_timeout_out,
   output logic [CNT_W-1:0] instret_out
);

   localparam int unsigned     TO_W    = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (DIV_TIMEOUT > 0) ? TO_W'(DIV_TIMEOUT - 1) : '0;
   localparam logic            TO_EN   = (DIV_TIMEOUT != 0);

   typedef enum logic {S_RUN, S_DIV_WAIT} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TO_W-1:0]   r_to_cnt;
   logic              w_stall;
   logic              w_ack;
   logic              w_timeout;
   logic              w_cnt_clr;
   logic              w_cnt_inc;
   logic              w_accept;
   logic              w_trap;
   logic [XLEN-1:0]   w_wdata;

   logic              r_rf_we;
   logic [4:0]        r_rf_waddr;
   logic [XLEN-1:0]   r_rf_wdata;
   logic              r_retire;
   logic [XLEN-1:0]   r_retire_pc;
   logic [31:0]       r_retire_instr;
   logic              r_trap;
   logic              r_div_to;
   logic [CNT_W-1:0]  r_instret;

   // Writeback data select; divider result overrides everything else.
   always_comb begin
      w_wdata = ALU_res_in;
      if (is_div_in) begin
         w_wdata = div_result_in;
      end else if (is_jalr_in || (WBSel_in == 2'b10)) begin
         w_wdata = pc_in + XLEN'(4);
      end else begin
         case (WBSel_in)
            2'b00:   w_wdata = mem_data_in;
            2'b11:   w_wdata = csr_rdata_in;
            default: w_wdata = ALU_res_in;
         endcase
      end
   end

   // Divider handshake FSM. The RUN-state stall cycle is the first waited
   // cycle, so with the counter starting at 0 in DIV_WAIT the stall lasts
   // exactly DIV_TIMEOUT cycles before the timeout trap is taken.
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_ack       = 1'b0;
      w_timeout   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (wb_valid_in && is_div_in && !trapReq_in) begin
               if (div_valid_in) begin
                  w_ack = 1'b1;
               end else begin
                  w_stall     = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = S_DIV_WAIT;
               end
            end
         end
         S_DIV_WAIT: begin
            if (!wb_valid_in) begin
               w_state_nxt = S_RUN;
            end else if (div_valid_in) begin
               w_ack       = 1'b1;
               w_state_nxt = S_RUN;
            end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_stall   = 1'b1;
               w_cnt_inc = 1'b1;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   assign w_accept = wb_valid_in && !w_stall;
   assign w_trap   = trapReq_in || w_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_RUN;
         r_to_cnt       <= '0;
         r_rf_we        <= 1'b0;
         r_rf_waddr     <= '0;
         r_rf_wdata     <= '0;
         r_retire       <= 1'b0;
         r_retire_pc    <= '0;
         r_retire_instr <= '0;
         r_trap         <= 1'b0;
         r_div_to       <= 1'b0;
         r_instret      <= '0;
      end else begin
         r_state  <= w_state_nxt;
         if (w_cnt_clr) begin
            r_to_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         r_rf_we  <= 1'b0;
         r_retire <= 1'b0;
         r_trap   <= 1'b0;
         r_div_to <= 1'b0;
         if (w_accept) begin
            r_retire_pc    <= pc_in;
            r_retire_instr <= instr_in;
            r_rf_waddr     <= addr_rd_in;
            r_rf_wdata     <= w_wdata;
            if (w_trap) begin
               r_trap   <= 1'b1;
               r_div_to <= w_timeout;
            end else begin
               r_rf_we   <= regWEn_in && (addr_rd_in != 5'd0);
               r_retire  <= 1'b1;
               r_instret <= r_instret + 1'b1;
            end
         end
      end
   end

   assign div_ack_out      = w_ack;
   assign stall_out        = w_stall;
   assign rf_we_out        = r_rf_we;
   assign rf_waddr_out     = r_rf_waddr;
   assign rf_wdata_out     = r_rf_wdata;
   assign retire_valid_out = r_retire;
   assign retire_pc_out    = r_retire_pc;
   assign retire_instr_out = r_retire_instr;
   assign trap_out         = r_trap;
   assign div_timeout_out  = r_div_to;
   assign instret_out      = r_instret;

endmodule

// File: tb/tb_wb_retire_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_retire_unit
//   Directed scenarios plus randomized instruction stream for wb_retire_unit.
//   dut  : XLEN=32, CNT_W=64, DIV_TIMEOUT=4
//   dut2 : CNT_W=4, DIV_TIMEOUT=0 (counter wrap, timeout disabled)
// ---------------------------------------------------------------------------
module tb_wb_retire_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, wb_valid, regWEn, trapReq, is_jalr, is_div, div_valid;
   logic [31:0] mem_data, alu_res, pc, instr, csr_rdata, div_result;
   logic [4:0]  addr_rd;
   logic [1:0]  wbsel;

   logic        div_ack, stall, rf_we, retire, trap, div_to;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, retire_pc, retire_instr;
   logic [63:0] instret;

   logic        d2_ack, d2_stall, d2_we, d2_retire, d2_trap, d2_to;
   logic [4:0]  d2_waddr;
   logic [31:0] d2_wdata, d2_pc, d2_instr;
   logic [3:0]  d2_instret;

   wb_retire_unit #(.XLEN(32), .CNT_W(64), .DIV_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .wb_valid_in(wb_valid), .mem_data_in(mem_data),
      .ALU_res_in(alu_res), .pc_in(pc), .instr_in(instr), .csr_rdata_in(csr_rdata),
      .addr_rd_in(addr_rd), .WBSel_in(wbsel), .regWEn_in(regWEn), .trapReq_in(trapReq),
      .is_jalr_in(is_jalr), .is_div_in(is_div), .div_valid_in(div_valid),
      .div_result_in(div_result), .div_ack_out(div_ack), .stall_out(stall),
      .rf_we_out(rf_we), .rf_waddr_out(rf_waddr), .rf_wdata_out(rf_wdata),
      .retire_valid_out(retire), .retire_pc_out(retire_pc), .retire_instr_out(retire_instr),
      .trap_out(trap), .div_timeout_out(div_to), .instret_out(instret));

   wb_retire_unit #(.XLEN(32), .CNT_W(4), .DIV_TIMEOUT(0)) dut2 (
      .clk(clk), .reset(reset), .wb_valid_in(wb_valid), .mem_data_in(mem_data),
      .ALU_res_in(alu_res), .pc_in(pc), .instr_in(instr), .csr_rdata_in(csr_rdata),
      .addr_rd_in(addr_rd), .WBSel_in(wbsel), .regWEn_in(regWEn), .trapReq_in(trapReq),
      .is_jalr_in(is_jalr), .is_div_in(is_div), .div_valid_in(div_valid),
      .div_result_in(div_result), .div_ack_out(d2_ack), .stall_out(d2_stall),
      .rf_we_out(d2_we), .rf_waddr_out(d2_waddr), .rf_wdata_out(d2_wdata),
      .retire_valid_out(d2_retire), .retire_pc_out(d2_pc), .retire_instr_out(d2_instr),
      .trap_out(d2_trap), .div_timeout_out(d2_to), .instret_out(d2_instret));

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      wb_valid = 1'b0; regWEn = 1'b0; trapReq = 1'b0; is_jalr = 1'b0;
      is_div = 1'b0; div_valid = 1'b0;
   endtask

   task automatic set_op(input logic [31:0] p, input logic [1:0] sel, input logic [4:0] rd,
                         input logic we, input logic jalr, input logic dv, input logic tr);
      wb_valid = 1'b1; pc = p; wbsel = sel; addr_rd = rd; regWEn = we;
      is_jalr = jalr; is_div = dv; trapReq = tr; div_valid = 1'b0;
      instr = $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_idle();
      tick();
      tick();
      n_cmp++; if ({rf_we, retire, trap, div_to} !== 4'b0) begin n_bad++;
         $display("FAIL reset_pulses got %b want 0000", {rf_we, retire, trap, div_to}); end
      n_cmp++; if (rf_wdata !== 32'd0 || rf_waddr !== 5'd0) begin n_bad++;
         $display("FAIL reset_rf got %h/%0d want 0/0", rf_wdata, rf_waddr); end
      n_cmp++; if (retire_pc !== 32'd0 || retire_instr !== 32'd0) begin n_bad++;
         $display("FAIL reset_retire got %h/%h want 0/0", retire_pc, retire_instr); end
      n_cmp++; if (instret !== 64'd0 || d2_instret !== 4'd0) begin n_bad++;
         $display("FAIL reset_instret got %0d/%0d want 0/0", instret, d2_instret); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++;
         $display("FAIL reset_stall got %b want 0", stall); end
      reset = 1'b0;
   endtask

   task automatic test_alu();
      set_op(32'h40, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      alu_res = 32'h1234; mem_data = 32'hAAAA; csr_rdata = 32'hBBBB;
      tick();
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_bad++;
         $display("FAIL alu_write got we=%b a=%0d d=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
      n_cmp++; if (instret !== 64'd1 || retire !== 1'b1 || retire_pc !== 32'h40) begin n_bad++;
         $display("FAIL alu_retire got n=%0d r=%b pc=%h want 1/1/40", instret, retire, retire_pc); end
      set_idle();
      tick();
      n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b0 || trap !== 1'b0) begin n_bad++;
         $display("FAIL idle_pulses got %b%b%b want 000", rf_we, retire, trap); end
      n_cmp++; if (rf_wdata !== 32'h1234 || retire_pc !== 32'h40 || instret !== 64'd1) begin n_bad++;
         $display("FAIL idle_hold got %h/%h/%0d want 1234/40/1", rf_wdata, retire_pc, instret); end
      // mem and CSR selects
      set_op(32'h44, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++; if (rf_wdata !== 32'hAAAA) begin n_bad++;
         $display("FAIL sel_mem got %h want aaaa", rf_wdata); end
      wbsel = 2'b11;
      tick();
      n_cmp++; if (rf_wdata !== 32'hBBBB || instret !== 64'd3) begin n_bad++;
         $display("FAIL sel_csr got %h/%0d want bbbb/3", rf_wdata, instret); end
   endtask

   task automatic test_jalr();
      set_op(32'h100, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      alu_res = 32'hDEAD;
      tick();
      n_cmp++; if (rf_wdata !== 32'h104 || rf_we !== 1'b1) begin n_bad++;
         $display("FAIL jalr_data got %h/%b want 104/1", rf_wdata, rf_we); end
      addr_rd = 5'd0;
      tick();
      n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b1 || instret !== 64'd5) begin n_bad++;
         $display("FAIL jalr_x0 got we=%b r=%b n=%0d want 0/1/5", rf_we, retire, instret); end
      set_op(32'hFFFF_FFFC, 2'b10, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++; if (rf_wdata !== 32'd0 || rf_we !== 1'b1) begin n_bad++;
         $display("FAIL pc4_wrap got %h/%b want 0/1", rf_wdata, rf_we); end
      set_idle();
      tick();
   endtask

   task automatic test_divide();
      set_op(32'h180, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      div_result = 32'hCAFE_BABE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (stall !== 1'b1 || div_ack !== 1'b0) begin n_bad++;
            $display("FAIL div_wait%0d got stall=%b ack=%b want 1/0", i, stall, div_ack); end
         tick();
         n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++;
            $display("FAIL div_wait_out%0d got %b%b want 00", i, rf_we, retire); end
      end
      div_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0 || div_ack !== 1'b1) begin n_bad++;
         $display("FAIL div_ack got stall=%b ack=%b want 0/1", stall, div_ack); end
      tick();
      n_cmp++; if (rf_wdata !== 32'hCAFE_BABE || rf_we !== 1'b1 || instret !== 64'd7) begin n_bad++;
         $display("FAIL div_done got %h/%b/%0d want cafebabe/1/7", rf_wdata, rf_we, instret); end
      set_idle();
      div_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (div_ack !== 1'b0) begin n_bad++;
         $display("FAIL ack_idle got %b want 0", div_ack); end
      tick();
      div_valid = 1'b0;
   endtask

   task automatic test_trap();
      set_op(32'h200, 2'b01, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_bad++;
         $display("FAIL trap_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (trap !== 1'b1 || div_to !== 1'b0 || rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++;
         $display("FAIL trap_pulse got t=%b to=%b we=%b r=%b want 1/0/0/0", trap, div_to, rf_we, retire); end
      n_cmp++; if (instret !== 64'd7 || retire_pc !== 32'h200) begin n_bad++;
         $display("FAIL trap_state got n=%0d pc=%h want 7/200", instret, retire_pc); end
      set_idle();
      tick();
      n_cmp++; if (trap !== 1'b0) begin n_bad++;
         $display("FAIL trap_once got %b want 0", trap); end
   endtask

   task automatic test_timeout();
      set_op(32'h300, 2'b00, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < int'(TO); i++) begin
         @(negedge clk);
         n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL to_stall%0d got %b want 1", i, stall); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0 || div_ack !== 1'b0 || d2_stall !== 1'b1) begin n_bad++;
         $display("FAIL to_release got s=%b a=%b s2=%b want 0/0/1", stall, div_ack, d2_stall); end
      tick();
      n_cmp++; if (trap !== 1'b1 || div_to !== 1'b1 || rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++;
         $display("FAIL to_trap got t=%b to=%b we=%b r=%b want 1/1/0/0", trap, div_to, rf_we, retire); end
      set_idle();
      tick();
      n_cmp++; if (trap !== 1'b0 || div_to !== 1'b0 || instret !== 64'd7) begin n_bad++;
         $display("FAIL to_after got %b/%b/%0d want 0/0/7", trap, div_to, instret); end
      // valid arriving on the timeout cycle wins
      set_op(32'h340, 2'b00, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      div_result = 32'h1357_9BDF;
      for (int i = 0; i < int'(TO); i++) tick();
      div_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (div_ack !== 1'b1 || stall !== 1'b0) begin n_bad++;
         $display("FAIL to_tie_ack got a=%b s=%b want 1/0", div_ack, stall); end
      tick();
      n_cmp++; if (trap !== 1'b0 || rf_we !== 1'b1 || rf_wdata !== 32'h1357_9BDF) begin n_bad++;
         $display("FAIL to_tie_wr got t=%b we=%b d=%h want 0/1/13579bdf", trap, rf_we, rf_wdata); end
      set_idle();
      tick();
   endtask

   task automatic test_reset_in_wait();
      set_op(32'h400, 2'b00, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_op(32'h404, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if ({rf_we, retire, trap, div_to} !== 4'b0 || instret !== 64'd0 || retire_pc !== 32'd0) begin n_bad++;
         $display("FAIL rstwait_out got %b n=%0d pc=%h want 0000/0/0", {rf_we, retire, trap, div_to}, instret, retire_pc); end
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_bad++;
         $display("FAIL rstwait_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (retire !== 1'b1 || instret !== 64'd1 || rf_we !== 1'b0) begin n_bad++;
         $display("FAIL rstwait_next got r=%b n=%0d we=%b want 1/1/0", retire, instret, rf_we); end
      set_idle();
      tick();
   endtask

   task automatic test_wrap();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_op(32'h500, 2'b01, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      n_cmp++; if (d2_instret !== 4'hF) begin n_bad++;
         $display("FAIL wrap_top got %h want f", d2_instret); end
      tick();
      n_cmp++; if (d2_instret !== 4'h0 || instret !== 64'd16) begin n_bad++;
         $display("FAIL wrap_zero got %h/%0d want 0/16", d2_instret, instret); end
      set_idle();
      tick();
   endtask

   function automatic logic [31:0] ref_wdata(input logic dv, input logic jalr, input logic [1:0] sel,
         input logic [31:0] m, input logic [31:0] a, input logic [31:0] p,
         input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      if (dv)                          r = d;
      else if (jalr || sel == 2'd2)    r = p + 32'd4;
      else if (sel == 2'd0)            r = m;
      else if (sel == 2'd1)            r = a;
      else                             r = c;
      return r;
   endfunction

   task automatic test_random();
      logic [63:0] m_instret;
      logic [31:0] m_pc;
      logic [31:0] m_wdata;
      logic        e_stall, e_ack, e_to, e_trap, e_we, done;
      int unsigned dly, waited;
      reset = 1'b1;
      set_idle();
      tick();
      reset = 1'b0;
      m_instret = 64'd0;
      m_pc = 32'd0;
      for (int n = 0; n < 400; n++) begin
         mem_data = $urandom; alu_res = $urandom; csr_rdata = $urandom;
         div_result = $urandom; addr_rd = 5'($urandom_range(31)); wbsel = 2'($urandom_range(3));
         if ($urandom_range(3) == 0) begin
            set_idle();
            is_div = 1'($urandom_range(1)); div_valid = 1'($urandom_range(1));
            pc = $urandom;
            @(negedge clk);
            n_cmp++; if (stall !== 1'b0 || div_ack !== 1'b0) begin n_bad++;
               $display("FAIL rnd_idle_comb n=%0d got s=%b a=%b want 0/0", n, stall, div_ack); end
            tick();
            n_cmp++; if ({rf_we, retire, trap} !== 3'b0 || retire_pc !== m_pc || instret !== m_instret) begin n_bad++;
               $display("FAIL rnd_idle n=%0d got %b pc=%h n=%0d want 000 pc=%h n=%0d",
                        n, {rf_we, retire, trap}, retire_pc, instret, m_pc, m_instret); end
         end else begin
            pc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            instr = $urandom;
            wb_valid = 1'b1;
            regWEn  = 1'($urandom_range(1));
            trapReq = ($urandom_range(7) == 0);
            is_div  = ($urandom_range(2) == 0);
            is_jalr = ($urandom_range(7) == 0);
            dly = $urandom_range(6);
            waited = 0;
            done = 1'b0;
            for (int w = 0; w < 20 && !done; w++) begin
               div_valid = is_div && !trapReq && (waited >= dly);
               e_ack   = is_div && !trapReq && div_valid;
               e_to    = is_div && !trapReq && !div_valid && (waited == TO);
               e_stall = is_div && !trapReq && !div_valid && !e_to;
               @(negedge clk);
               n_cmp++; if (stall !== e_stall || div_ack !== e_ack) begin n_bad++;
                  $display("FAIL rnd_comb n=%0d w=%0d got s=%b a=%b want s=%b a=%b", n, w, stall, div_ack, e_stall, e_ack); end
               tick();
               if (e_stall) begin
                  n_cmp++; if ({rf_we, retire, trap} !== 3'b0) begin n_bad++;
                     $display("FAIL rnd_stall_out n=%0d got %b want 000", n, {rf_we, retire, trap}); end
               end else begin
                  done = 1'b1;
                  e_trap = trapReq || e_to;
                  e_we = !e_trap && regWEn && (addr_rd != 5'd0);
                  m_pc = pc;
                  if (!e_trap) m_instret = m_instret + 64'd1;
                  m_wdata = ref_wdata(is_div, is_jalr, wbsel, mem_data, alu_res, pc, csr_rdata, div_result);
                  n_cmp++; if (trap !== e_trap || div_to !== e_to || retire !== !e_trap || rf_we !== e_we) begin n_bad++;
                     $display("FAIL rnd_ctl n=%0d got t=%b to=%b r=%b we=%b want %b/%b/%b/%b",
                              n, trap, div_to, retire, rf_we, e_trap, e_to, !e_trap, e_we); end
                  n_cmp++; if (retire_pc !== m_pc || retire_instr !== instr || instret !== m_instret) begin n_bad++;
                     $display("FAIL rnd_ret n=%0d got pc=%h i=%h n=%0d want %h/%h/%0d",
                              n, retire_pc, retire_instr, instret, m_pc, instr, m_instret); end
                  if (e_we) begin
                     n_cmp++; if (rf_waddr !== addr_rd || rf_wdata !== m_wdata) begin n_bad++;
                        $display("FAIL rnd_wr n=%0d got %0d/%h want %0d/%h", n, rf_waddr, rf_wdata, addr_rd, m_wdata); end
                  end
               end
               waited++;
            end
            if (!done) begin
               n_cmp++; n_bad++;
               $display("FAIL rnd_bound n=%0d instruction never completed", n);
            end
            div_valid = 1'b0;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      mem_data = '0; alu_res = '0; pc = '0; instr = '0; csr_rdata = '0;
      div_result = '0; addr_rd = '0; wbsel = '0;
      test_reset();
      test_alu();
      test_jalr();
      test_divide();
      test_trap();
      test_timeout();
      test_reset_in_wait();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
